// File: rtl/update_scheduler.sv
// Per-p-bit update-strobe scheduler: one-hot or even/odd slots with dwell, skip mask and sweep reporting.
// Outputs are registered and change one edge after the deciding inputs; there is no backpressure, enable=0 pauses.
module update_scheduler #(
   parameter int N_PBITS = 5,
   parameter int DWELL_W = 4,
   parameter int SWEEP_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               mode,
   input  logic [N_PBITS-1:0] skip_mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [N_PBITS-1:0] update_out,
   output logic               sweep_done,
   output logic [SWEEP_W-1:0] sweep_count
);

   localparam int SW = (N_PBITS > 1) ? $clog2(N_PBITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_STARVED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SW-1:0]      slot_q, slot_d;
   logic               mode_q, mode_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] dcnt_q, dcnt_d;
   logic [N_PBITS-1:0] update_q, update_d;
   logic               sweep_done_q, sweep_done_d;
   logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;

   logic               start;
   logic               wrap;

   // Strobe pattern of one slot; slots beyond the mode's slot count yield zero.
   function automatic logic [N_PBITS-1:0] pattern(input logic m, input logic [SW-1:0] s);
      logic [N_PBITS-1:0] p;
      p = '0;
      for (int i = 0; i < N_PBITS; i++) begin
         if (m) begin
            if (int'(s) < 2) p[i] = ((i % 2) == int'(s));
         end else begin
            p[i] = (int'(s) == i);
         end
      end
      return p;
   endfunction

   // Returns {found, index} of the lowest active slot, optionally restricted to indices above lo.
   function automatic logic [SW:0] find_slot(input logic m, input logic [N_PBITS-1:0] msk,
                                             input logic use_lo, input logic [SW-1:0] lo);
      logic [SW:0] res;
      res = '0;
      for (int k = N_PBITS - 1; k >= 0; k--) begin
         if ((!use_lo || (k > int'(lo))) && ((pattern(m, SW'(k)) & ~msk) != '0)) begin
            res = {1'b1, SW'(k)};
         end
      end
      return res;
   endfunction

   logic        cur_act_in;
   logic [SW:0] above_in;
   logic [SW:0] low_in;
   logic [SW:0] above_q;

   assign cur_act_in = ((pattern(mode, slot_q) & ~skip_mask) != '0);
   assign above_in   = find_slot(mode, skip_mask, 1'b1, slot_q);
   assign low_in     = find_slot(mode, skip_mask, 1'b0, '0);
   assign above_q    = find_slot(mode_q, skip_mask, 1'b1, slot_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         slot_q       <= '0;
         mode_q       <= 1'b0;
         dwell_q      <= '0;
         dcnt_q       <= '0;
         update_q     <= '0;
         sweep_done_q <= 1'b0;
         sweep_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         mode_q       <= mode_d;
         dwell_q      <= dwell_d;
         dcnt_q       <= dcnt_d;
         update_q     <= update_d;
         sweep_done_q <= sweep_done_d;
         sweep_cnt_q  <= sweep_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      mode_d  = mode_q;
      dwell_d = dwell_q;
      dcnt_d  = dcnt_q;
      start   = 1'b0;
      wrap    = 1'b0;
      if (!enable) begin
         // Pause keeps the slot pointer so the interrupted slot can resume.
         state_d = S_IDLE;
         dcnt_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               mode_d = mode;
               if (cur_act_in) begin
                  state_d = S_RUN;
                  start   = 1'b1;
               end else if (above_in[SW]) begin
                  state_d = S_RUN;
                  slot_d  = above_in[SW-1:0];
                  start   = 1'b1;
               end else if (low_in[SW]) begin
                  state_d = S_RUN;
                  slot_d  = low_in[SW-1:0];
                  start   = 1'b1;
               end else begin
                  state_d = S_STARVED;
               end
            end
            S_STARVED: begin
               if (low_in[SW]) begin
                  state_d = S_RUN;
                  mode_d  = mode;
                  slot_d  = low_in[SW-1:0];
                  start   = 1'b1;
               end
            end
            S_RUN: begin
               if (dcnt_q == dwell_q) begin
                  if (above_q[SW]) begin
                     slot_d = above_q[SW-1:0];
                     start  = 1'b1;
                  end else begin
                     // End of sweep: the new sweep runs under the freshly sampled mode.
                     mode_d = mode;
                     if (low_in[SW]) begin
                        slot_d = low_in[SW-1:0];
                        start  = 1'b1;
                        wrap   = 1'b1;
                     end else begin
                        state_d = S_STARVED;
                        dcnt_d  = '0;
                     end
                  end
               end else begin
                  dcnt_d = dcnt_q + DWELL_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               dcnt_d  = '0;
            end
         endcase
         if (start) begin
            dcnt_d  = '0;
            dwell_d = dwell;
         end
      end
   end

   always_comb begin
      update_d     = update_q;
      sweep_done_d = wrap;
      sweep_cnt_d  = sweep_cnt_q + {{(SWEEP_W-1){1'b0}}, wrap};
      if (state_d != S_RUN) begin
         update_d = '0;
      end else if (start) begin
         update_d = pattern(mode_d, slot_d) & ~skip_mask;
      end
   end

   assign update_out  = update_q;
   assign sweep_done  = sweep_done_q;
   assign sweep_count = sweep_cnt_q;

endmodule

// File: tb/tb_update_scheduler.sv
// Directed bench for update_scheduler with hand-computed strobe sequences.
module tb_update_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        mode = 1'b0;
   logic [4:0]  skip_mask = '0;
   logic [3:0]  dwell = '0;
   logic [4:0]  update_out;
   logic        sweep_done;
   logic [15:0] sweep_count;

   int total = 0;
   int bad = 0;

   update_scheduler #(.N_PBITS(5), .DWELL_W(4), .SWEEP_W(16)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .mode(mode),
      .skip_mask(skip_mask),
      .dwell(dwell),
      .update_out(update_out),
      .sweep_done(sweep_done),
      .sweep_count(sweep_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [4:0] upd, input logic sd, input logic [15:0] cnt);
      step();
      chk({tag, ".upd"}, {27'd0, update_out}, {27'd0, upd});
      chk({tag, ".sd"}, {31'd0, sweep_done}, {31'd0, sd});
      chk({tag, ".cnt"}, {16'd0, sweep_count}, {16'd0, cnt});
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".upd"}, {27'd0, update_out}, 32'd0);
      chk({tag, ".sd"}, {31'd0, sweep_done}, 32'd0);
      chk({tag, ".cnt"}, {16'd0, sweep_count}, 32'd0);
   endtask

   // Asserts reset between edges, checks the async clear, then releases with new settings.
   task automatic restart(input logic m, input logic [3:0] dw, input logic [4:0] msk);
      #2;
      reset = 1'b1;
      #1;
      check_zero("reset");
      enable = 1'b1;
      mode = m;
      dwell = dw;
      skip_mask = msk;
      step();
      reset = 1'b0;
   endtask

   task automatic seq_basic(input string tag);
      expect_out({tag, "0"}, 5'b00001, 1'b0, 16'd0);
      expect_out({tag, "1"}, 5'b00010, 1'b0, 16'd0);
      expect_out({tag, "2"}, 5'b00100, 1'b0, 16'd0);
      expect_out({tag, "3"}, 5'b01000, 1'b0, 16'd0);
      expect_out({tag, "4"}, 5'b10000, 1'b0, 16'd0);
      expect_out({tag, "wrap"}, 5'b00001, 1'b1, 16'd1);
      expect_out({tag, "after"}, 5'b00010, 1'b0, 16'd1);
   endtask

   initial begin
      // Power-up with enable high from reset release.
      step();
      check_zero("por");
      enable = 1'b1;
      step();
      check_zero("por_held");
      reset = 1'b0;
      seq_basic("seq");

      // Dwell of 2: every slot held three cycles.
      restart(1'b0, 4'd2, 5'b00000);
      for (int k = 0; k < 5; k++) begin
         for (int r = 0; r < 3; r++) begin
            expect_out("dwell", 5'b00001 << k, 1'b0, 16'd0);
         end
      end
      expect_out("dwell_wrap", 5'b00001, 1'b1, 16'd1);
      expect_out("dwell_hold", 5'b00001, 1'b0, 16'd1);

      // Two-colour mode with p-bit 2 clamped.
      restart(1'b1, 4'd0, 5'b00100);
      expect_out("col_e0", 5'b10001, 1'b0, 16'd0);
      expect_out("col_o0", 5'b01010, 1'b0, 16'd0);
      expect_out("col_e1", 5'b10001, 1'b1, 16'd1);
      expect_out("col_o1", 5'b01010, 1'b0, 16'd1);
      expect_out("col_e2", 5'b10001, 1'b1, 16'd2);

      // Everything clamped while running, then a single slot freed.
      restart(1'b0, 4'd0, 5'b00000);
      expect_out("mask_s0", 5'b00001, 1'b0, 16'd0);
      skip_mask = 5'b11111;
      expect_out("starve0", 5'b00000, 1'b0, 16'd0);
      expect_out("starve1", 5'b00000, 1'b0, 16'd0);
      skip_mask = 5'b11110;
      expect_out("unstarve", 5'b00001, 1'b0, 16'd0);
      expect_out("single_w1", 5'b00001, 1'b1, 16'd1);
      expect_out("single_w2", 5'b00001, 1'b1, 16'd2);

      // Pause during slot 2 with dwell 3, resume five cycles later.
      restart(1'b0, 4'd3, 5'b00000);
      for (int r = 0; r < 4; r++) expect_out("p_s0", 5'b00001, 1'b0, 16'd0);
      for (int r = 0; r < 4; r++) expect_out("p_s1", 5'b00010, 1'b0, 16'd0);
      expect_out("p_s2a", 5'b00100, 1'b0, 16'd0);
      expect_out("p_s2b", 5'b00100, 1'b0, 16'd0);
      enable = 1'b0;
      for (int r = 0; r < 5; r++) expect_out("paused", 5'b00000, 1'b0, 16'd0);
      enable = 1'b1;
      for (int r = 0; r < 4; r++) expect_out("resume_s2", 5'b00100, 1'b0, 16'd0);
      expect_out("resume_s3", 5'b01000, 1'b0, 16'd0);

      // Mode change mid-sweep takes effect only at the wrap.
      restart(1'b0, 4'd0, 5'b00000);
      expect_out("mc_0", 5'b00001, 1'b0, 16'd0);
      expect_out("mc_1", 5'b00010, 1'b0, 16'd0);
      mode = 1'b1;
      expect_out("mc_2", 5'b00100, 1'b0, 16'd0);
      expect_out("mc_3", 5'b01000, 1'b0, 16'd0);
      expect_out("mc_4", 5'b10000, 1'b0, 16'd0);
      expect_out("mc_even", 5'b10101, 1'b1, 16'd1);
      expect_out("mc_odd", 5'b01010, 1'b0, 16'd1);
      expect_out("mc_even2", 5'b10101, 1'b1, 16'd2);

      // Mid-slot async reset, then a restart identical to power-up.
      restart(1'b0, 4'd0, 5'b00000);
      seq_basic("rst_seq");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
